// File: rtl/game_pkg.sv
// game_pkg: shared button indices and attack repeat FSM states.
package game_pkg;
  localparam int NUM_BTN    = 7;
  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_JUMP   = 2;
  localparam int BTN_SQUAT  = 3;
  localparam int BTN_ATTACK = 4;
  localparam int BTN_DEFEND = 5;
  localparam int BTN_SELECT = 6;
  typedef enum logic {ATK_IDLE, ATK_HELD} atk_state_t;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchronizer, debounce counter and rising-edge detect for one active-low button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic rise
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0]    sync_q;
  logic          stable_q;
  logic          prev_q;
  logic [DW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q <= {sync_q[0], ~btn_n};
      prev_q <= stable_q;
      if (sync_q[1] == stable_q) cnt_q <= '0;
      else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        stable_q <= ~stable_q;
        cnt_q    <= '0;
      end else cnt_q <= cnt_q + 1'b1;
    end
  end
  assign level = stable_q;
  assign rise  = stable_q & ~prev_q;
endmodule

// File: rtl/input_ctrl.sv
// input_ctrl: debounced, gated game-controller inputs with attack auto-repeat.
module input_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_CYCLES   = 12_500_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] i_btn_n,
  input  logic               i_is_gaming,
  output logic               right,
  output logic               left,
  output logic               jump,
  output logic               squat,
  output logic               attack,
  output logic               defend,
  output logic               select
);
  localparam int RW = $clog2(REPEAT_CYCLES);
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] rise;
  atk_state_t         state_q, state_d;
  logic [RW-1:0]      rep_q, rep_d;
  logic               atk_pulse;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (i_btn_n[i]),
      .level (lvl[i]),
      .rise  (rise[i])
    );
  end
  // Leaving HELD never pulses; re-entry needs a fresh debounced press.
  always_comb begin
    state_d   = state_q;
    rep_d     = '0;
    atk_pulse = 1'b0;
    if (state_q == ATK_IDLE) begin
      if (rise[BTN_ATTACK] && i_is_gaming) begin
        state_d   = ATK_HELD;
        atk_pulse = 1'b1;
      end
    end else if (!lvl[BTN_ATTACK] || !i_is_gaming) state_d = ATK_IDLE;
    else begin
      atk_pulse = rep_q == RW'(REPEAT_CYCLES - 1);
      rep_d     = atk_pulse ? '0 : rep_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ATK_IDLE;
      rep_q   <= '0;
      right   <= 1'b0;
      left    <= 1'b0;
      jump    <= 1'b0;
      squat   <= 1'b0;
      attack  <= 1'b0;
      defend  <= 1'b0;
      select  <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      right   <= lvl[BTN_RIGHT] & ~lvl[BTN_LEFT] & i_is_gaming;
      left    <= lvl[BTN_LEFT] & ~lvl[BTN_RIGHT] & i_is_gaming;
      jump    <= rise[BTN_JUMP] & i_is_gaming;
      squat   <= lvl[BTN_SQUAT] & i_is_gaming;
      attack  <= atk_pulse;
      defend  <= lvl[BTN_DEFEND] & i_is_gaming;
      select  <= rise[BTN_SELECT];
    end
  end
endmodule

// File: doc/input_ctrl.md
# input_ctrl

Front-end for the game's button inputs. Takes the seven raw active-low board buttons, synchronizes and debounces each one, and drives the `right/left/jump/squat/attack/defend/select` inputs of the game controller. Movement and stance inputs come out as clean levels. `jump`, `attack` and `select` come out as single-cycle press pulses, and `attack` auto-repeats while held.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); minimum 2.
- `REPEAT_CYCLES`, default 12_500_000: period of `attack` auto-repeat pulses while held; minimum 2.
- `clk`  in  1: system clock. Single clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `i_btn_n`  in  7: raw buttons, active-low, asynchronous to `clk`. Index order: right=0, left=1, jump=2, squat=3, attack=4, defend=5, select=6.
- `i_is_gaming`  in  1: high while the game is in the play state.
- `right`, `left`, `squat`, `defend`  out  1 each: debounced held levels.
- `jump`, `attack`, `select`  out  1 each: single-cycle pulses.

## Operation
- **Per channel, synchronizer:** 2-FF synchronizer. It is reset to "released", i.e. the synchronized active-high value is 0.
- **Per channel, debouncer:**
  - The debouncer holds an accepted level `stable` and a counter.
  - If the synchronized value equals `stable`, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1`, `stable` toggles and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `stable`.
- **Edge detect:** `rise` = `stable` went 0→1 this cycle.
- **Level outputs:**
  - `squat` and `defend` are registered copies of `stable & i_is_gaming`.
  - `right` and `left` are registered copies of `stable & i_is_gaming`, with one exception: if both are stable-pressed, both outputs are 0 (neutral).
- **`jump`:** registered `rise & i_is_gaming`.
- **`select`:** registered `rise`. It does not depend on `i_is_gaming`.
- **`attack` repeat FSM** (states IDLE, HELD):
  - IDLE → HELD on `rise & i_is_gaming`. The pulse is emitted and the repeat counter is cleared.
  - In HELD, the repeat counter increments each cycle. At `REPEAT_CYCLES-1` it emits a pulse and clears.
  - HELD → IDLE when `stable`=0 or `i_is_gaming`=0. The counter is cleared and no pulse is emitted on that cycle.
  - If the button is still held when `i_is_gaming` rises, no pulse is emitted. A new press is required.
- **Reset values:** every output 0, every `stable` 0, all counters 0, FSM in IDLE.
- **Button held through reset:** after `rst_n` deasserts, the button is debounced normally and produces one `rise`. This is intended: holding select across reset starts a game.
- **Widths:**
  - The debounce counter is `$clog2(DEBOUNCE_CYCLES)` bits and the repeat counter is `$clog2(REPEAT_CYCLES)` bits.
  - Neither counter ever wraps. Each clears on reaching its terminal value.

## Timing
- **Press latency:** raw edge sampled at cycle 0 → synchronized value at cycle 2 → `stable` updates at cycle `DEBOUNCE_CYCLES+1` → outputs visible at cycle `DEBOUNCE_CYCLES+2`.
- **Release latency:** same as press latency. Level outputs drop `DEBOUNCE_CYCLES+2` cycles after the raw release.
- **Pulse width:** every pulse is exactly 1 cycle.
- **Repeat spacing:** in HELD, pulses are exactly `REPEAT_CYCLES` cycles apart.
- **Gating latency:** `i_is_gaming` gating acts on the register input, so outputs respond 1 cycle after `i_is_gaming` changes.
- **Reset mid-operation:** asserting `rst_n` low mid-count or mid-repeat clears all state immediately (asynchronously). No pulse is emitted on reset exit unless the button is pressed and then debounced again.
- **No handshake:** consumers sample the outputs every cycle.

## Structure
- **Sub-module `button_debounce`:** one instance per channel (7 total).
  - Contains the 2-FF synchronizer, the debounce counter and `stable`.
  - Outputs `level` and `rise`.
  - Parameter: `DEBOUNCE_CYCLES`.
- **Top level:** holds the left/right exclusion, the gating, the output registers and the attack repeat FSM.
- **`game_pkg` additions:**
  - Button index constants `BTN_RIGHT`…`BTN_SELECT` (0…6) and `NUM_BTN = 7`.
  - Enum `atk_state_t` {`ATK_IDLE`, `ATK_HELD`}.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `REPEAT_CYCLES`=8, with `i_is_gaming`=1 unless noted.
- **Clean press/release:** drive `i_btn_n[0]` low at cycle 10 and high at cycle 40 → `right` rises at cycle 16 and falls at cycle 46. All other outputs stay 0.
- **Glitch rejection:** pulse `i_btn_n[2]` low for 3 cycles → `jump` stays 0. A 10-cycle press → exactly one 1-cycle `jump` pulse, 6 cycles after the raw edge.
- **Auto-repeat:** hold `i_btn_n[4]` low for 30 cycles starting at cycle 0 → `attack` pulses at cycles 6, 14, 22 and 30 → no further pulses after release.
- **Left/right both held, then gating:**
  - Hold both left and right → `right`=`left`=0. Release left → `right`=1 after debounce.
  - Drop `i_is_gaming` → `right`=0 one cycle later.
- **Select vs. gating:** with `i_is_gaming`=0, press select → one `select` pulse. Press attack → no `attack` pulse.
- **Reset mid-repeat:** with attack held and in HELD, drive `rst_n` low → all outputs 0 immediately. After reset release with the button still held → one `attack` pulse at 6 cycles, then repeat pulses resume.
